// File: rtl/chase_pkg.sv
// chase_pkg: shared definitions for the seven-segment chaser controller.
// Holds the mode encoding, the blank-scan pattern, parameter defaults for
// chase_ctrl and the one-hot active-low scan helper.
package chase_pkg;

    localparam logic [1:0] MODE_LEFT  = 2'd0;
    localparam logic [1:0] MODE_RIGHT = 2'd1;
    localparam logic [1:0] MODE_STOP  = 2'd2;

    localparam logic [7:0] SCAN_OFF = 8'hFF;

    localparam int unsigned PW_DEF         = 31;
    localparam int unsigned PERIOD_RST_DEF = 60_000_000;
    localparam int unsigned PERIOD_MIN_DEF = 8_000_000;
    localparam int unsigned PERIOD_MAX_DEF = 1_000_000_000;
    localparam int unsigned STEP_DN_DEF    = 8_000_000;
    localparam int unsigned STEP_UP_DEF    = 10_000_000;
    localparam int unsigned DB_CYCLES_DEF  = 1_000_000;

    typedef enum logic [1:0] {
        ST_LEFT  = MODE_LEFT,
        ST_RIGHT = MODE_RIGHT,
        ST_STOP  = MODE_STOP
    } mode_e;

    // Active-low one-hot digit enable for digit index p.
    function automatic logic [7:0] scan_onehot(input logic [2:0] p);
        return ~(8'b1 << p);
    endfunction

endpackage

// File: rtl/chase_btn_cond.sv
// btn_cond: conditions one raw push-button into a single-cycle press pulse.
// Path: 2-flop synchroniser -> conditioner -> rising-edge detector (registered).
// Optional macro CHASE_DEBOUNCE_EN: conditioner is a debounce filter that only
// accepts a new level after DB_CYCLES consecutive differing samples; without
// it the conditioner is a plain wire and DB_CYCLES has no effect.
// Ports:
//   clk   in  system clock
//   rst   in  asynchronous active-high reset
//   raw   in  asynchronous button level
//   press out one-cycle pulse per accepted rising edge
module btn_cond #(
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    logic sync1;
    logic sync2;
    logic clean;
    logic clean_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

`ifdef CHASE_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    logic [CW-1:0] db_cnt;

    // Counter runs only while the synchronised level disagrees with the
    // accepted level; any agreement restarts the stability window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt <= '0;
            clean  <= 1'b0;
        end else if (sync2 == clean) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_cnt <= '0;
            clean  <= sync2;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end
`else
    assign clean = sync2;

    // DB_CYCLES is accepted for interface compatibility but unused here.
    if (DB_CYCLES == 0) begin : g_db_unused
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clean_d <= 1'b0;
            press   <= 1'b0;
        end else begin
            clean_d <= clean;
            press   <= clean & ~clean_d;
        end
    end

endmodule

// File: rtl/chase_ctrl.sv
// chase_ctrl: control/scheduling for the 8-digit seven-segment chaser.
// Conditions five buttons, runs the LEFT/RIGHT/STOP mode FSM, holds the
// saturating step-period register, generates the step tick and drives the
// active-low one-hot digit scan.
// Optional macro CHASE_DEBOUNCE_EN enables the debounce filter in btn_cond.
// Ports:
//   clk                          in  system clock
//   rst                          in  asynchronous active-high reset
//   btnu/btnd/btnl/btnr/btnc     in  raw buttons (faster/slower/left/right/stop)
//   mode   [1:0]                 out 0 LEFT, 1 RIGHT, 2 STOP
//   period [PW-1:0]              out clk cycles per step
//   tick                         out one-cycle step strobe
//   pos    [2:0]                 out lit digit index
//   scan   [7:0]                 out active-low one-hot digit enables
//
// state   | meaning
// ST_LEFT | chasing, pos increments on tick
// ST_RIGHT| chasing, pos decrements on tick
// ST_STOP | halted, counter held at 0, all digits blanked
module chase_ctrl
    import chase_pkg::*;
#(
    parameter int unsigned PW         = PW_DEF,
    parameter int unsigned PERIOD_RST = PERIOD_RST_DEF,
    parameter int unsigned PERIOD_MIN = PERIOD_MIN_DEF,
    parameter int unsigned PERIOD_MAX = PERIOD_MAX_DEF,
    parameter int unsigned STEP_DN    = STEP_DN_DEF,
    parameter int unsigned STEP_UP    = STEP_UP_DEF,
    parameter int unsigned DB_CYCLES  = DB_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          btnu,
    input  logic          btnd,
    input  logic          btnl,
    input  logic          btnr,
    input  logic          btnc,
    output logic [1:0]    mode,
    output logic [PW-1:0] period,
    output logic          tick,
    output logic [2:0]    pos,
    output logic [7:0]    scan
);

    localparam logic [PW:0] P_MIN     = (PW+1)'(PERIOD_MIN);
    localparam logic [PW:0] P_MAX     = (PW+1)'(PERIOD_MAX);
    localparam logic [PW:0] P_UP      = (PW+1)'(STEP_UP);
    localparam logic [PW:0] P_DEC_THR = (PW+1)'(PERIOD_MIN + STEP_DN);

    logic press_u, press_d, press_l, press_r, press_c;

    btn_cond #(.DB_CYCLES(DB_CYCLES)) u_btn_u (.clk(clk), .rst(rst), .raw(btnu), .press(press_u));
    btn_cond #(.DB_CYCLES(DB_CYCLES)) u_btn_d (.clk(clk), .rst(rst), .raw(btnd), .press(press_d));
    btn_cond #(.DB_CYCLES(DB_CYCLES)) u_btn_l (.clk(clk), .rst(rst), .raw(btnl), .press(press_l));
    btn_cond #(.DB_CYCLES(DB_CYCLES)) u_btn_r (.clk(clk), .rst(rst), .raw(btnr), .press(press_r));
    btn_cond #(.DB_CYCLES(DB_CYCLES)) u_btn_c (.clk(clk), .rst(rst), .raw(btnc), .press(press_c));

    mode_e state_q;
    mode_e state_n;
    logic  mode_chg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LEFT;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        mode_chg = 1'b0;
        if (press_l) begin
            state_n = ST_LEFT;
        end else if (press_r) begin
            state_n = ST_RIGHT;
        end else if (press_c) begin
            state_n = ST_STOP;
        end
        mode_chg = (state_n != state_q);
    end

    assign mode = state_q;

    // Period arithmetic carries one extra bit so the upward sum cannot wrap
    // before it is compared against the saturation bound.
    logic [PW-1:0] period_q;
    logic [PW-1:0] period_n;
    logic [PW:0]   sum_up;

    assign sum_up = {1'b0, period_q} + P_UP;

    always_comb begin
        period_n = period_q;
        if (press_u && !press_d) begin
            if ({1'b0, period_q} >= P_DEC_THR) begin
                period_n = period_q - PW'(STEP_DN);
            end else begin
                period_n = P_MIN[PW-1:0];
            end
        end else if (press_d && !press_u) begin
            if (sum_up <= P_MAX) begin
                period_n = sum_up[PW-1:0];
            end else begin
                period_n = P_MAX[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_q <= PW'(PERIOD_RST);
        end else begin
            period_q <= period_n;
        end
    end

    assign period = period_q;

    // Tick counter: '>=' lets a period that shrinks below the running count
    // wrap on the next cycle instead of counting through the full range.
    logic [PW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (mode_chg || state_q == ST_STOP) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt >= period_q - PW'(1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos  <= 3'd0;
            scan <= scan_onehot(3'd0);
        end else begin
            if (tick) begin
                if (state_q == ST_RIGHT) begin
                    pos <= pos - 3'd1;
                end else begin
                    pos <= pos + 3'd1;
                end
            end
            scan <= (state_q == ST_STOP) ? SCAN_OFF : scan_onehot(pos);
        end
    end

endmodule

// File: tb/tb_chase_ctrl.sv
module tb_chase_ctrl;

    localparam int PRST = 6;
    localparam int PMIN = 2;
    localparam int PMAX = 12;
    localparam int SDN  = 2;
    localparam int SUP  = 3;
    localparam int DB   = 4;
`ifdef CHASE_DEBOUNCE_EN
    localparam int PL = DB + 3;
`else
    localparam int PL = 3;
`endif
    localparam int HL = 16;
    localparam int P0_B = (PL + 1 > PRST) ? 1 : 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  btn = 5'b0;   // 0:u 1:d 2:l 3:r 4:c
    logic [1:0]  mode;
    logic [30:0] period;
    logic        tick;
    logic [2:0]  pos;
    logic [7:0]  scan;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 0;

    always #5 clk = ~clk;

    chase_ctrl #(
        .PW(31), .PERIOD_RST(PRST), .PERIOD_MIN(PMIN), .PERIOD_MAX(PMAX),
        .STEP_DN(SDN), .STEP_UP(SUP), .DB_CYCLES(DB)
    ) dut (
        .clk(clk), .rst(rst),
        .btnu(btn[0]), .btnd(btn[1]), .btnl(btn[2]), .btnr(btn[3]), .btnc(btn[4]),
        .mode(mode), .period(period), .tick(tick), .pos(pos), .scan(scan)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] scan_of(input int p);
        logic [7:0] one;
        one = 8'd1 << p;
        return ~one;
    endfunction

    // Reference model: button levels go through a sample history; presses are
    // derived from the history, then mode/period/timer/display follow the rules.
    logic [HL-1:0] m_hist [5];
    logic [4:0]    m_clean, m_clean_d, m_press;
    int            m_mode, m_period, m_cnt, m_pos;
    logic          m_tick;
    logic [7:0]    m_scan;

    always @(posedge clk or posedge rst) begin : model
        logic [HL-1:0] h;
        logic [4:0]    cl_n;
        int            mode_n;
        int            per_n;
        bit            same;
        if (rst) begin
            for (int b = 0; b < 5; b++) m_hist[b] <= '0;
            m_clean   <= '0;
            m_clean_d <= '0;
            m_press   <= '0;
            m_mode    <= 0;
            m_period  <= PRST;
            m_cnt     <= 0;
            m_tick    <= 1'b0;
            m_pos     <= 0;
            m_scan    <= 8'hFE;
        end else begin
            cl_n = '0;
            for (int b = 0; b < 5; b++) begin
                h = {m_hist[b][HL-2:0], btn[b]};
                m_hist[b] <= h;
`ifdef CHASE_DEBOUNCE_EN
                same = 1'b1;
                for (int j = 3; j <= DB + 1; j++) if (h[j] != h[2]) same = 1'b0;
                cl_n[b] = same ? h[2] : m_clean[b];
`else
                same = 1'b0;
                cl_n[b] = h[1];
`endif
            end
            m_clean   <= cl_n;
            m_clean_d <= m_clean;
            m_press   <= m_clean & ~m_clean_d;

            mode_n = m_press[2] ? 0 : m_press[3] ? 1 : m_press[4] ? 2 : m_mode;
            per_n  = m_period;
            if (m_press[0] && !m_press[1]) per_n = (m_period - SDN < PMIN) ? PMIN : m_period - SDN;
            if (m_press[1] && !m_press[0]) per_n = (m_period + SUP > PMAX) ? PMAX : m_period + SUP;

            if (mode_n != m_mode || m_mode == 2) begin
                m_cnt <= 0; m_tick <= 1'b0;
            end else if (m_cnt + 1 >= m_period) begin
                m_cnt <= 0; m_tick <= 1'b1;
            end else begin
                m_cnt <= m_cnt + 1; m_tick <= 1'b0;
            end
            if (m_tick) m_pos <= (m_mode == 0) ? (m_pos + 1) % 8 : (m_pos + 7) % 8;
            m_scan   <= (m_mode == 2) ? 8'hFF : scan_of(m_pos);
            m_mode   <= mode_n;
            m_period <= per_n;
        end
    end

    always @(negedge clk) begin
        if (chk_on && !rst) begin
            chk("model_mode", mode, m_mode);
            chk("model_period", period, m_period);
            chk("model_tick", tick, m_tick);
            chk("model_pos", pos, m_pos);
            chk("model_scan", scan, m_scan);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic press_btn(input logic [4:0] m);
        btn = m;
        repeat (PL + 4) @(negedge clk);
        btn = '0;
        repeat (PL + 4) @(negedge clk);
    endtask

    task automatic wait_mode(input int want, output int gap);
        gap = 0;
        while (mode !== 2'(want) && gap < 100) begin
            @(negedge clk);
            gap++;
        end
        chk("mode_reach", mode, want);
    endtask

    task automatic wait_tick(input int start, output int gap);
        gap = start;
        do begin
            @(negedge clk);
            gap++;
        end while (tick !== 1'b1 && gap < 100);
    endtask

    typedef struct {
        logic [4:0] b;
        int         mode;
        int         period;
    } vec_t;
    vec_t tbl[17];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int g;
        int held;
        tbl[0]  = '{5'b00001, 0, 4};
        tbl[1]  = '{5'b00001, 0, 2};
        tbl[2]  = '{5'b00001, 0, 2};
        tbl[3]  = '{5'b00010, 0, 5};
        tbl[4]  = '{5'b00010, 0, 8};
        tbl[5]  = '{5'b00010, 0, 11};
        tbl[6]  = '{5'b00010, 0, 12};
        tbl[7]  = '{5'b00010, 0, 12};
        tbl[8]  = '{5'b01000, 1, 12};
        tbl[9]  = '{5'b10000, 2, 12};
        tbl[10] = '{5'b01100, 0, 12};
        tbl[11] = '{5'b00011, 0, 12};
        tbl[12] = '{5'b11000, 1, 12};
        tbl[13] = '{5'b10100, 0, 12};
        tbl[14] = '{5'b10000, 2, 12};
        tbl[15] = '{5'b00001, 2, 10};
        tbl[16] = '{5'b00100, 0, 10};

        repeat (3) @(negedge clk);
        chk("rst_mode", mode, 0);
        chk("rst_period", period, PRST);
        chk("rst_scan", scan, 8'hFE);
        rst = 1'b0;
        chk_on = 1;

        // btnr at pos 0
        btn = 5'b01000;
        wait_mode(1, g);
        chk("btnr_latency", g, PL + 1);
        wait_tick(0, g);
        chk("btnr_first_tick", g, PRST);
        @(negedge clk);
        chk("btnr_pos", pos, (P0_B + 7) % 8);
        @(negedge clk);
        chk("btnr_scan", scan, scan_of((P0_B + 7) % 8));
        btn = '0;

        // idle chase from reset
        do_reset();
        g = 0;
        for (int k = 1; k <= 9; k++) begin
            wait_tick((k == 1) ? 0 : 2, g);
            chk("idle_gap", g, PRST);
            @(negedge clk);
            chk("idle_pos", pos, k % 8);
            @(negedge clk);
            chk("idle_scan", scan, scan_of(k % 8));
        end

        // stop then resume left
        btn = 5'b10000;
        wait_mode(2, g);
        btn = '0;
        held = m_pos;
        @(negedge clk);
        for (int i = 0; i < 50; i++) begin
            chk("stop_scan", scan, 8'hFF);
            chk("stop_tick", tick, 0);
            @(negedge clk);
        end
        btn = 5'b00100;
        wait_mode(0, g);
        btn = '0;
        @(negedge clk);
        chk("resume_scan", scan, scan_of(held));
        wait_tick(1, g);
        chk("resume_first_tick", g, PRST);

        // shrink period mid-count
        repeat (PL + 4) @(negedge clk);
        press_btn(5'b00010);
        press_btn(5'b00010);
        chk("shrink_setup", period, 12);
        wait_tick(0, g);
        repeat (8 - PL) @(negedge clk);
        btn = 5'b00001;
        wait_tick(8 - PL, g);
        chk("shrink_gap", g, 10);
        btn = '0;
        wait_tick(0, g);
        chk("shrink_next_gap", g, 10);

        // table of press sequences from reset
        do_reset();
        for (int i = 0; i < 17; i++) begin
            press_btn(tbl[i].b);
            chk("tbl_mode", mode, tbl[i].mode);
            chk("tbl_period", period, tbl[i].period);
        end

        // conditioner timing
`ifdef CHASE_DEBOUNCE_EN
        btn = 5'b10000;
        repeat (2) @(negedge clk);
        btn = '0;
        repeat (20) @(negedge clk);
        chk("glitch_ignored", mode, 0);
`endif
        btn = 5'b01000;
        wait_mode(1, g);
        chk("press_latency", g, PL + 1);
        repeat (20 - g) @(negedge clk);
        btn = '0;
        repeat (20) @(negedge clk);
        btn = 5'b00001;
        repeat (20) @(negedge clk);
        btn = '0;
        repeat (20) @(negedge clk);
        chk("hold_one_pulse", period, 8);

        // randomized button activity against the model
        for (int i = 0; i < 800; i++) begin
            int bi;
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) begin
                bi = $urandom_range(0, 4);
                btn[bi] = ~btn[bi];
            end
        end
        btn = '0;
        repeat (20) @(negedge clk);

        // asynchronous reset mid-period
        press_btn(5'b01000);
        press_btn(5'b00010);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_mode", mode, 0);
        chk("arst_period", period, PRST);
        chk("arst_tick", tick, 0);
        chk("arst_pos", pos, 0);
        chk("arst_scan", scan, 8'hFE);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
